// File: rtl/xy_motion_ctrl.sv
// Two-axis target-seeking position controller with step/dir pulses, busy/done and abort.
// Optional build macro XY_LIMIT_EN clamps captured targets to X_MAX/Y_MAX.
module xy_motion_ctrl #(
    parameter int WIDTH    = 8,
    parameter int STEP_DIV = 4,
    parameter int X_MAX    = 2**WIDTH-1,
    parameter int Y_MAX    = 2**WIDTH-1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ena_i,
    input  logic             motion_i,
    input  logic             mode_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] x_target_i,
    input  logic [WIDTH-1:0] y_target_i,
    output logic [WIDTH-1:0] x_pos_o,
    output logic [WIDTH-1:0] y_pos_o,
    output logic             x_step_o,
    output logic             y_step_o,
    output logic             x_dir_o,
    output logic             y_dir_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, CAPTURE, MOVE_XY, MOVE_X, MOVE_Y, DONE
    } state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q, sync2_dly_q;
    logic             mode_q;
    logic [WIDTH-1:0] x_pos_q, y_pos_q, x_tgt_q, y_tgt_q;
    logic [PW-1:0]    pre_q;
    logic             x_step_q, y_step_q, x_dir_q, y_dir_q, busy_q, done_q;

    logic             motion_edge;
    logic             tick;
    logic             x_eq, y_eq, x_up_d, y_up_d;
    logic [WIDTH-1:0] x_nxt_d, y_nxt_d;
    logic [WIDTH-1:0] x_cap_d, y_cap_d;

    assign motion_edge = sync2_q & ~sync2_dly_q;
    assign tick        = (pre_q == PRE_LAST);
    assign x_eq        = (x_pos_q == x_tgt_q);
    assign y_eq        = (y_pos_q == y_tgt_q);
    assign x_up_d      = (x_tgt_q > x_pos_q);
    assign y_up_d      = (y_tgt_q > y_pos_q);
    assign x_nxt_d     = x_up_d ? x_pos_q + 1'b1 : x_pos_q - 1'b1;
    assign y_nxt_d     = y_up_d ? y_pos_q + 1'b1 : y_pos_q - 1'b1;

`ifdef XY_LIMIT_EN
    localparam logic [WIDTH-1:0] X_LIM = WIDTH'(X_MAX);
    localparam logic [WIDTH-1:0] Y_LIM = WIDTH'(Y_MAX);
    assign x_cap_d = (x_target_i > X_LIM) ? X_LIM : x_target_i;
    assign y_cap_d = (y_target_i > Y_LIM) ? Y_LIM : y_target_i;
`else
    assign x_cap_d = x_target_i;
    assign y_cap_d = y_target_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
            mode_q      <= 1'b0;
            x_pos_q     <= '0;
            y_pos_q     <= '0;
            x_tgt_q     <= '0;
            y_tgt_q     <= '0;
            pre_q       <= '0;
            x_step_q    <= 1'b0;
            y_step_q    <= 1'b0;
            x_dir_q     <= 1'b0;
            y_dir_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (ena_i) begin
            sync1_q     <= motion_i;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
            x_step_q    <= 1'b0;
            y_step_q    <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (motion_edge) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        x_tgt_q <= x_cap_d;
                        y_tgt_q <= y_cap_d;
                        mode_q  <= mode_i;
                        pre_q   <= '0;
                        state_q <= mode_i ? MOVE_X : MOVE_XY;
                    end
                end
                MOVE_XY: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (x_eq && y_eq) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        pre_q <= tick ? '0 : pre_q + 1'b1;
                        if (tick && !x_eq) begin
                            x_pos_q  <= x_nxt_d;
                            x_dir_q  <= x_up_d;
                            x_step_q <= 1'b1;
                        end
                        if (tick && !y_eq) begin
                            y_pos_q  <= y_nxt_d;
                            y_dir_q  <= y_up_d;
                            y_step_q <= 1'b1;
                        end
                    end
                end
                MOVE_X: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (x_eq) begin
                        // prescaler restarts so Y gets a full step period
                        state_q <= MOVE_Y;
                        pre_q   <= '0;
                    end else begin
                        pre_q <= tick ? '0 : pre_q + 1'b1;
                        if (tick) begin
                            x_pos_q  <= x_nxt_d;
                            x_dir_q  <= x_up_d;
                            x_step_q <= 1'b1;
                        end
                    end
                end
                MOVE_Y: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (y_eq) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        pre_q <= tick ? '0 : pre_q + 1'b1;
                        if (tick) begin
                            y_pos_q  <= y_nxt_d;
                            y_dir_q  <= y_up_d;
                            y_step_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x_pos_o  = x_pos_q;
    assign y_pos_o  = y_pos_q;
    assign x_step_o = x_step_q;
    assign y_step_o = y_step_q;
    assign x_dir_o  = x_dir_q;
    assign y_dir_o  = y_dir_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule
